// File: rtl/booth_mult_param.sv
// booth_mult_param: multi-cycle radix-2 Booth multiplier, signed or unsigned operands.
// Optional early termination when the remaining Booth digits are zero: define MULT_EARLY_TERM_EN.
module booth_mult_param #(
    parameter int W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_signed,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    output logic [2*W-1:0]   result,
    output logic             busy,
    output logic             done
);
    localparam int AW = 2 * W + 2;
    localparam int CW = $clog2(W + 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] acc, acc_nx, xs;
    logic [W:0]    ys;
    logic          yp;
    logic [CW-1:0] i;
    logic          last;

    // xs holds x_ext<<i and ys holds y_ext>>>i, so the current Booth pair is {ys[0], yp}
    always_comb begin
        acc_nx = ({ys[0], yp} == 2'b01) ? acc + xs :
                 ({ys[0], yp} == 2'b10) ? acc - xs : acc;
`ifdef MULT_EARLY_TERM_EN
        last = (i == CW'(W)) || (ys == '0) || (ys == '1);
`else
        last = (i == CW'(W));
`endif
    end

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb
        state_nx = (state == IDLE) ? (start ? RUN : IDLE) :
                   (state == RUN)  ? (last ? DONE : RUN) : IDLE;

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk)
        if (rst) begin
            acc    <= '0;
            xs     <= '0;
            ys     <= '0;
            yp     <= 1'b0;
            i      <= '0;
            result <= '0;
        end else if (state == IDLE && start) begin
            acc <= '0;
            xs  <= {{(W + 2){op_signed & x[W-1]}}, x};
            ys  <= {op_signed & y[W-1], y};
            yp  <= 1'b0;
            i   <= '0;
        end else if (state == RUN) begin
            acc <= acc_nx;
            xs  <= xs << 1;
            ys  <= {ys[W], ys[W:1]};
            yp  <= ys[0];
            i   <= i + 1'b1;
            if (last) result <= acc_nx[2*W-1:0];
        end
endmodule

// File: tb/tb_booth_mult_param.sv
// tb_booth_mult_param: directed and random checks of booth_mult_param against an arithmetic model.
module tb_booth_mult_param;
    localparam int W = 6;

    logic             clk = 1'b0;
    logic             rst, start, op_signed;
    logic [W-1:0]     x, y;
    logic [2*W-1:0]   result;
    logic             busy, done;
    int               total = 0, passed = 0;

    booth_mult_param #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op_signed(op_signed),
        .x(x), .y(y), .result(result), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [2*W-1:0] ref_prod(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        longint av, bv;
        logic [63:0] p;
        av = sgn ? longint'($signed(a)) : longint'(a);
        bv = sgn ? longint'($signed(b)) : longint'(b);
        p  = 64'(av * bv);
        return p[2*W-1:0];
    endfunction

    // edges after the start edge until done is visible: one per Booth step processed
    function automatic int ref_lat(input logic sgn, input logic [W-1:0] b);
        int k = 0;
`ifdef MULT_EARLY_TERM_EN
        longint v;
        v = sgn ? longint'($signed(b)) : longint'(b);
        while (!(v == 0 || v == -1) && k < W) begin
            v = v >>> 1;
            k++;
        end
`else
        k = W;
`endif
        return k + 1;
    endfunction

    task automatic do_op(input string tag, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp, input bit pulse_again);
        int n = 0;
        @(negedge clk);
        start = 1'b1; op_signed = sgn; x = a; y = b;
        @(posedge clk); #1;
        start = 1'b0;
        x = W'($urandom); y = W'($urandom); op_signed = 1'($urandom);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        do begin
            @(posedge clk); #1;
            n++;
            start = pulse_again && n == 1;
        end while (!done && n < 40);
        chk({tag, "_lat"}, 64'(n), 64'(ref_lat(sgn, b)));
        chk({tag, "_res"}, 64'(result), 64'(exp));
        chk({tag, "_busy_done"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_done_1cyc"}, 64'(done), 64'd0);
        chk({tag, "_hold"}, 64'(result), 64'(exp));
    endtask

    initial begin
        logic [W-1:0] a, b;
        logic         s;
        int           pulses;
        rst = 1'b1; start = 1'b1; op_signed = 1'b0; x = '0; y = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_res", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;

        do_op("neg32sq", 1'b1, 6'b100000, 6'b100000, 12'h400, 1'b0);
        do_op("u63sq", 1'b0, 6'd63, 6'd63, 12'hF81, 1'b0);
        do_op("s1sq", 1'b1, 6'd63, 6'd63, 12'h001, 1'b0);
        do_op("s5xm3", 1'b1, 6'd5, 6'b111101, 12'hFF1, 1'b1);
        do_op("y0", 1'b0, 6'd21, 6'd0, 12'h000, 1'b0);

        // abort during RUN: no done pulse, result cleared
        @(negedge clk);
        start = 1'b1; op_signed = 1'b0; x = 6'd13; y = 6'd47;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_res", 64'(result), 64'd0);
        pulses = 0;
        repeat (12) begin
            @(posedge clk); #1;
            pulses += int'(done);
        end
        chk("abort_no_done", 64'(pulses), 64'd0);
        chk("abort_res_after", 64'(result), 64'd0);
        do_op("u7x9", 1'b0, 6'd7, 6'd9, 12'h03F, 1'b0);

        for (int k = 0; k < 40; k++) begin
            s = 1'($urandom);
            a = W'($urandom);
            b = (k % 8 == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            do_op("rand", s, a, b, ref_prod(s, a, b), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
